// File: rtl/iram_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iram_loader_pkg                                                      |
// | Shared state encoding and framing constants for the IRAM loader.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package iram_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/iram_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iram_loader_if                                                       |
// | Byte stream, IRAM write port and boot status of the IRAM loader.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface iram_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reload;
    logic              iram_wena;
    logic [ADDR_W-1:0] iram_addr;
    logic [31:0]       iram_wdata;
    logic              cpu_rst;
    logic              load_done;
    logic              load_err;

    modport master (
        output in_data, in_valid, reload,
        input  in_ready, iram_wena, iram_addr, iram_wdata, cpu_rst, load_done, load_err
    );

    modport slave (
        input  in_data, in_valid, reload,
        output in_ready, iram_wena, iram_addr, iram_wdata, cpu_rst, load_done, load_err
    );
endinterface
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_packer                                                          |
// | Packs bytes big-endian into 32-bit words; word_valid with 4th byte.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module byte_packer
    import iram_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_we,
    output logic [31:0] word_out,
    output logic        word_valid
);
    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (byte_we) begin
            r_shift <= {r_shift[15:0], byte_in};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    // The completed word is presented combinationally so the consumer can
    // register it on the same edge that accepts the final byte.
    assign word_out   = {r_shift, byte_in};
    assign word_valid = byte_we && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/iram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iram_loader                                                          |
// | Boot loader: frames a byte stream into IRAM and holds the CPU in     |
// | reset until done. Define CHECKSUM_EN for a trailing checksum word.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    iram_loader_if.slave bus
);
    localparam logic [31:0] c_depth = 32'(2 ** ADDR_W);

    state_t            r_state;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W-1:0] r_k;
    logic              r_in_ready;
    logic              r_wena;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_err;

    logic              w_xfer;
    logic              w_reload;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic              w_last;

    assign w_xfer   = bus.in_valid && r_in_ready;
    assign w_reload = bus.reload && ((r_state == S_DONE) || (r_state == S_ERR));
    assign w_last   = ({1'b0, r_k} == (r_n - 1'b1));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_reload),
        .byte_in    (bus.in_data),
        .byte_we    (w_xfer),
        .word_out   (w_word),
        .word_valid (w_word_valid)
    );

`ifdef CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst || w_reload || (r_state == S_HDR)) begin
            r_sum <= '0;
        end else if ((r_state == S_DATA) && w_word_valid) begin
            r_sum <= r_sum + w_word;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HDR;
            r_n        <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b1;
            r_wena     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wena <= 1'b0;
            unique case (r_state)
                S_HDR: begin
                    if (w_word_valid) begin
                        r_k <= '0;
                        if (w_word == '0) begin
`ifdef CHECKSUM_EN
                            r_state <= S_CSUM;
`else
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_cpu_rst  <= 1'b0;
                            r_done     <= 1'b1;
`endif
                        end else if (w_word > c_depth) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                            r_n     <= w_word[ADDR_W:0];
                        end
                    end
                end
                S_DATA: begin
                    if (w_word_valid) begin
                        r_wena  <= 1'b1;
                        r_addr  <= r_k;
                        r_wdata <= w_word;
                        // k stops at the last word so it never passes DEPTH-1.
                        if (w_last) begin
`ifdef CHECKSUM_EN
                            r_state <= S_CSUM;
`else
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_cpu_rst  <= 1'b0;
                            r_done     <= 1'b1;
`endif
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
`ifdef CHECKSUM_EN
                S_CSUM: begin
                    if (w_word_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_word == r_sum) begin
                            r_state   <= S_DONE;
                            r_cpu_rst <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    if (bus.reload) begin
                        r_state    <= S_HDR;
                        r_k        <= '0;
                        r_in_ready <= 1'b1;
                        r_cpu_rst  <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_HDR;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.iram_wena  = r_wena;
    assign bus.iram_addr  = r_addr;
    assign bus.iram_wdata = r_wdata;
    assign bus.cpu_rst    = r_cpu_rst;
    assign bus.load_done  = r_done;
    assign bus.load_err   = r_err;

endmodule
`default_nettype wire
